// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler: writer, latest-complete and reader banks for a shared frame BRAM.
// Define FRAME_STATS_EN to build the drop/repeat statistics counters; otherwise they read as 0.
module frame_bank_scheduler #(
    parameter int ADDR_W      = 18,
    parameter int FRAME_WORDS = 76800
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_wr_frame_start,
    input  logic              i_wr_frame_done,
    input  logic              i_rd_frame_start,
    output logic [1:0]        o_wr_bank,
    output logic [1:0]        o_rd_bank,
    output logic [ADDR_W-1:0] o_wr_base,
    output logic [ADDR_W-1:0] o_rd_base,
    output logic              o_rd_valid,
    output logic              o_wr_active,
    output logic [15:0]       o_drop_cnt,
    output logic [15:0]       o_repeat_cnt
);

    typedef enum logic {
        W_IDLE,
        W_ACTIVE
    } wr_state_t;

    localparam logic [ADDR_W-1:0] BASE0 = '0;
    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(2 * FRAME_WORDS);

    wr_state_t         wr_state_q, wr_state_d;
    logic [1:0]        wr_bank_q, wr_bank_d;
    logic [1:0]        latest_q, latest_d;
    logic [1:0]        rd_bank_q, rd_bank_d;
    logic              fresh_q, fresh_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic              publish;

    function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] idx);
        case (idx)
            2'd0:    bank_base = BASE0;
            2'd1:    bank_base = BASE1;
            2'd2:    bank_base = BASE2;
            default: bank_base = BASE0;
        endcase
    endfunction

    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        latest_d   = latest_q;
        rd_bank_d  = rd_bank_q;
        fresh_d    = fresh_q;
        rd_valid_d = rd_valid_q;
        publish    = 1'b0;

        if (!i_enable) begin
            wr_state_d = W_IDLE;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (i_wr_frame_start) wr_state_d = W_ACTIVE;
                end
                W_ACTIVE: begin
                    // start without done is an abort: stay active on the same bank
                    if (i_wr_frame_done) begin
                        publish    = 1'b1;
                        wr_state_d = i_wr_frame_start ? W_ACTIVE : W_IDLE;
                    end
                end
                default: wr_state_d = W_IDLE;
            endcase

            // Reader sees the pre-cycle state; publish then applies on top of its result.
            if (i_rd_frame_start && fresh_q) begin
                rd_bank_d  = latest_q;
                latest_d   = rd_bank_q;
                fresh_d    = 1'b0;
                rd_valid_d = 1'b1;
            end

            if (publish) begin
                wr_bank_d = latest_d;
                latest_d  = wr_bank_q;
                fresh_d   = 1'b1;
            end
        end

        wr_base_d = bank_base(wr_bank_d);
        rd_base_d = bank_base(rd_bank_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_state_q <= W_IDLE;
            wr_bank_q  <= 2'd0;
            latest_q   <= 2'd1;
            rd_bank_q  <= 2'd2;
            fresh_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_base_q  <= BASE0;
            rd_base_q  <= BASE2;
        end else begin
            wr_state_q <= wr_state_d;
            wr_bank_q  <= wr_bank_d;
            latest_q   <= latest_d;
            rd_bank_q  <= rd_bank_d;
            fresh_q    <= fresh_d;
            rd_valid_q <= rd_valid_d;
            wr_base_q  <= wr_base_d;
            rd_base_q  <= rd_base_d;
        end
    end

    assign o_wr_bank   = wr_bank_q;
    assign o_rd_bank   = rd_bank_q;
    assign o_wr_base   = wr_base_q;
    assign o_rd_base   = rd_base_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_wr_active = (wr_state_q == W_ACTIVE);

`ifdef FRAME_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] repeat_cnt_q, repeat_cnt_d;
    logic        drop_evt, repeat_evt;

    always_comb begin
        // A simultaneous reader swap consumes the pending frame, so that publish drops nothing.
        drop_evt     = publish && fresh_q && !i_rd_frame_start;
        repeat_evt   = i_enable && i_rd_frame_start && !fresh_q && rd_valid_q;
        drop_cnt_d   = drop_cnt_q;
        repeat_cnt_d = repeat_cnt_q;
        if (drop_evt && (drop_cnt_q != 16'hFFFF))     drop_cnt_d   = drop_cnt_q + 16'd1;
        if (repeat_evt && (repeat_cnt_q != 16'hFFFF)) repeat_cnt_d = repeat_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_q   <= '0;
            repeat_cnt_q <= '0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
        end
    end

    assign o_drop_cnt   = drop_cnt_q;
    assign o_repeat_cnt = repeat_cnt_q;
`else
    assign o_drop_cnt   = '0;
    assign o_repeat_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Self-checking bench for frame_bank_scheduler: vector table driven through an expected-value
// scoreboard, plus hand-written reset and long-frame sequences.
module tb_frame_bank_scheduler;

    localparam int ADDR_W = 18;
    localparam int FW     = 76800;
`ifdef FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, en, ws, wd, rs;
    logic [1:0]        o_wr_bank, o_rd_bank;
    logic [ADDR_W-1:0] o_wr_base, o_rd_base;
    logic              o_rd_valid, o_wr_active;
    logic [15:0]       o_drop_cnt, o_repeat_cnt;

    frame_bank_scheduler #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enable         (en),
        .i_wr_frame_start (ws),
        .i_wr_frame_done  (wd),
        .i_rd_frame_start (rs),
        .o_wr_bank        (o_wr_bank),
        .o_rd_bank        (o_rd_bank),
        .o_wr_base        (o_wr_base),
        .o_rd_base        (o_rd_base),
        .o_rd_valid       (o_rd_valid),
        .o_wr_active      (o_wr_active),
        .o_drop_cnt       (o_drop_cnt),
        .o_repeat_cnt     (o_repeat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] wr;
        logic [1:0] rd;
        logic       valid;
        logic       active;
        int         drop;
        int         rep;
    } exp_t;

    typedef struct {
        logic en, ws, wd, rs;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[30];

    function automatic exp_t mk_exp(input logic [1:0] wr, rd, input logic v, a, input int d, r);
        exp_t e;
        e.wr = wr; e.rd = rd; e.valid = v; e.active = a; e.drop = d; e.rep = r;
        return e;
    endfunction

    function automatic vec_t mk(input logic en_, ws_, wd_, rs_,
                                input logic [1:0] wr, rd, input logic v, a, input int d, r);
        vec_t t;
        t.en = en_; t.ws = ws_; t.wd = wd_; t.rs = rs_;
        t.e  = mk_exp(wr, rd, v, a, d, r);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".wr_bank"},  32'(o_wr_bank),  32'(e.wr));
        check({tag, ".rd_bank"},  32'(o_rd_bank),  32'(e.rd));
        check({tag, ".wr_base"},  32'(o_wr_base),  32'(e.wr) * FW);
        check({tag, ".rd_base"},  32'(o_rd_base),  32'(e.rd) * FW);
        check({tag, ".rd_valid"}, 32'(o_rd_valid), 32'(e.valid));
        check({tag, ".wr_active"}, 32'(o_wr_active), 32'(e.active));
        check({tag, ".drop_cnt"}, 32'(o_drop_cnt), STATS ? 32'(e.drop) : 32'd0);
        check({tag, ".repeat_cnt"}, 32'(o_repeat_cnt), STATS ? 32'(e.rep) : 32'd0);
        check({tag, ".distinct"}, 32'((o_wr_bank != o_rd_bank) && (o_wr_bank < 2'd3) && (o_rd_bank < 2'd3)), 32'd1);
    endtask

    task automatic step(input string tag, input logic en_, ws_, wd_, rs_, input exp_t e);
        en = en_; ws = ws_; wd = wd_; rs = rs_;
        sb.push_back(e);
        @(posedge clk);
        #1;
        en = 1'b1; ws = 1'b0; wd = 1'b0; rs = 1'b0;
        compare(tag);
    endtask

    task automatic reset_cycle(input string tag, input logic ws_);
        rst = 1'b1; ws = ws_;
        sb.push_back(mk_exp(2'd0, 2'd2, 1'b0, 1'b0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0; ws = 1'b0;
        compare(tag);
    endtask

    initial begin
        //          en ws wd rs   wr rd  v  a  drop rep
        tbl[0]  = mk(1, 0, 0, 1,   0, 2, 0, 0, 0, 0);  // rd_start, nothing completed
        tbl[1]  = mk(1, 1, 0, 0,   0, 2, 0, 1, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0,   0, 2, 0, 1, 0, 0);
        tbl[3]  = mk(1, 0, 1, 0,   1, 2, 0, 0, 0, 0);  // publish
        tbl[4]  = mk(1, 0, 0, 1,   1, 0, 1, 0, 0, 0);  // reader takes frame
        tbl[5]  = mk(1, 0, 0, 1,   1, 0, 1, 0, 0, 1);  // repeat
        tbl[6]  = mk(1, 1, 0, 0,   1, 0, 1, 1, 0, 1);
        tbl[7]  = mk(1, 0, 1, 0,   2, 0, 1, 0, 0, 1);
        tbl[8]  = mk(1, 1, 0, 0,   2, 0, 1, 1, 0, 1);
        tbl[9]  = mk(1, 0, 1, 0,   1, 0, 1, 0, 1, 1);  // second publish drops first
        tbl[10] = mk(1, 0, 0, 1,   1, 2, 1, 0, 1, 1);
        tbl[11] = mk(1, 1, 0, 0,   1, 2, 1, 1, 1, 1);
        tbl[12] = mk(1, 0, 1, 0,   0, 2, 1, 0, 1, 1);
        tbl[13] = mk(1, 1, 0, 0,   0, 2, 1, 1, 1, 1);
        tbl[14] = mk(1, 0, 1, 1,   2, 1, 1, 0, 1, 1);  // done + rd_start, fresh=1
        tbl[15] = mk(1, 0, 0, 1,   2, 0, 1, 0, 1, 1);
        tbl[16] = mk(1, 1, 0, 0,   2, 0, 1, 1, 1, 1);
        tbl[17] = mk(1, 1, 0, 0,   2, 0, 1, 1, 1, 1);  // abort
        tbl[18] = mk(1, 0, 1, 0,   1, 0, 1, 0, 1, 1);
        tbl[19] = mk(1, 0, 0, 1,   1, 2, 1, 0, 1, 1);
        tbl[20] = mk(1, 0, 1, 0,   1, 2, 1, 0, 1, 1);  // done while idle
        tbl[21] = mk(1, 1, 0, 0,   1, 2, 1, 1, 1, 1);
        tbl[22] = mk(1, 1, 1, 0,   0, 2, 1, 1, 1, 1);  // start + done while active
        tbl[23] = mk(1, 0, 1, 0,   1, 2, 1, 0, 2, 1);
        tbl[24] = mk(0, 1, 1, 1,   1, 2, 1, 0, 2, 1);  // disabled
        tbl[25] = mk(1, 1, 0, 0,   1, 2, 1, 1, 2, 1);
        tbl[26] = mk(0, 0, 1, 1,   1, 2, 1, 0, 2, 1);  // disabled forces idle
        tbl[27] = mk(1, 0, 1, 0,   1, 2, 1, 0, 2, 1);
        tbl[28] = mk(1, 0, 0, 1,   1, 0, 1, 0, 2, 1);
        tbl[29] = mk(1, 0, 0, 1,   1, 0, 1, 0, 2, 2);

        rst = 1'b1; en = 1'b1; ws = 1'b0; wd = 1'b0; rs = 1'b0;
        @(posedge clk);
        #1;
        reset_cycle("reset", 1'b0);

        for (int i = 0; i < 30; i++)
            step($sformatf("row%0d", i), tbl[i].en, tbl[i].ws, tbl[i].wd, tbl[i].rs, tbl[i].e);

        // Long frame: done ten cycles after start, then display picks it up.
        reset_cycle("reset2", 1'b0);
        step("long.start", 1, 1, 0, 0, mk_exp(2'd0, 2'd2, 1'b0, 1'b1, 0, 0));
        for (int i = 0; i < 9; i++)
            step($sformatf("long.gap%0d", i), 1, 0, 0, 0, mk_exp(2'd0, 2'd2, 1'b0, 1'b1, 0, 0));
        step("long.done", 1, 0, 1, 0, mk_exp(2'd1, 2'd2, 1'b0, 1'b0, 0, 0));
        check("long.latest", 32'(2'd3 ^ o_wr_bank ^ o_rd_bank), 32'd0);
        step("long.rd", 1, 0, 0, 1, mk_exp(2'd1, 2'd0, 1'b1, 1'b0, 0, 0));

        // Reset while writing: interrupted frame must never reach the reader.
        step("mid.start", 1, 1, 0, 0, mk_exp(2'd1, 2'd0, 1'b1, 1'b1, 0, 0));
        reset_cycle("mid.reset", 1'b1);
        step("mid.rd", 1, 0, 0, 1, mk_exp(2'd0, 2'd2, 1'b0, 1'b0, 0, 0));

        check("scoreboard.drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_bank_scheduler.md
Name: frame_bank_scheduler

Overview:
- Triple-buffer bank scheduler for the pixel frame-buffer BRAM shared by the camera write path and the display read path.
- Tracks three equal-size banks, one each for the writer, the latest completed frame and the display reader.
- Publishes completed frames and hands the newest one to the display at each display frame start, so the display never reads a bank being written (no tearing).
- Sits in the pixel-clock domain. Camera frame events arrive already synchronised as single-cycle pulses. The block drives the bank base addresses that the write and read address counters add to their pixel offsets.

Parameters:
- ADDR_W, 18, width of BRAM word address and base-address outputs.
- FRAME_WORDS, 76800, words per bank (320x240 RGB565); bank k base = k*FRAME_WORDS; 3*FRAME_WORDS must fit in ADDR_W bits.

Ports:
- i_clk  in  1  pixel clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_enable  in  1  1 = accept events; 0 = ignore all pulses, writer forced to W_IDLE, bank indices held.
- i_wr_frame_start  in  1  pulse: camera frame begins (first vde of frame).
- i_wr_frame_done  in  1  pulse: camera frame complete (last pixel written).
- i_rd_frame_start  in  1  pulse: display frame begins (start of vsync).
- o_wr_bank  out  2  bank index the writer must use.
- o_rd_bank  out  2  bank index the reader must use.
- o_wr_base  out  ADDR_W  o_wr_bank*FRAME_WORDS.
- o_rd_base  out  ADDR_W  o_rd_bank*FRAME_WORDS.
- o_rd_valid  out  1  1 once the reader holds a completed frame; 0 = display must blank.
- o_wr_active  out  1  writer state is W_ACTIVE.
- o_drop_cnt  out  16  frames overwritten before display (saturating).
- o_repeat_cnt  out  16  display frames that reused the previous bank (saturating).

Behaviour:
- Reset (i_rst=1 at clock edge):
  - wr_bank=0, latest=1, rd_bank=2; base addresses follow.
  - fresh=0, o_rd_valid=0, writer state W_IDLE, both counters 0.
- Invariant: wr_bank, latest and rd_bank are always pairwise distinct. Every update is a permutation of the three indices.
- Writer FSM:
  - W_IDLE + start -> W_ACTIVE.
  - W_ACTIVE + done -> W_IDLE and publish.
  - W_ACTIVE + start (missing done) -> abort: frame discarded, stay W_ACTIVE on the same bank.
  - done in W_IDLE is ignored.
  - start and done in the same cycle in W_ACTIVE: publish, then re-enter W_ACTIVE.
- Publish:
  - swap wr_bank and latest.
  - if fresh was already 1, o_drop_cnt+1.
  - set fresh=1 and has_frame=1.
- Reader event (i_rd_frame_start):
  - if fresh=1: swap rd_bank and latest, fresh=0, o_rd_valid=1.
  - else: bank unchanged; o_repeat_cnt+1 only if o_rd_valid=1.
- Simultaneous reader event and publish: reader is evaluated first against the pre-cycle state, then publish. Net result when fresh=1 beforehand:
  - rd_bank <= old latest.
  - latest <= old wr_bank.
  - wr_bank <= old rd_bank.
  - fresh=1, and o_drop_cnt does not increment.
- Latency: all outputs are registered and reflect an event on the clock edge after the pulse. Bases update in the same cycle as their bank index, computed from the next-state index; no multiplier, the three constants are selected.
- Counters saturate at 16'hFFFF.
- Reset mid-frame returns to reset values immediately; the interrupted frame is never published.

Optional Feature:
- FRAME_STATS_EN defined: o_drop_cnt and o_repeat_cnt are implemented as above.
- Not defined: both outputs are constant 0 and the counter registers are not built. Bank behaviour is identical either way.

Test Plan:
- Reset, then rd_start with no completed frame -> o_rd_bank=2, o_rd_valid=0, o_repeat_cnt=0.
- wr_start, then done 10 cycles later, then rd_start -> after done: o_wr_bank=1, latest=0. After rd_start: o_rd_bank=0, o_rd_base=0, o_rd_valid=1, o_wr_base=76800.
- Two complete write frames, no rd_start, then rd_start -> o_drop_cnt=1, o_rd_bank = bank of the second frame, all three indices distinct.
- Done pulse and rd_start on the same cycle with fresh=1 -> next cycle rd=old latest, latest=old wr, wr=old rd, drop_cnt unchanged.
- wr_start, wr_start again (abort), then done -> o_wr_bank unchanged until done; exactly one publish.
- i_enable=0 during start/done/rd_start pulses -> no output change. i_rst mid-W_ACTIVE -> wr=0, rd=2, o_wr_active=0, o_rd_valid=0 next cycle.
